// File: rtl/arbitro_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr_if
// Description : FIFO-side bundle of the round-robin arbiter (input-FIFO
//               status and head words in, pop/push/data and status out).
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_rr_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 10
);
    logic [NUM_PORTS-1:0]            empty;
    logic [NUM_PORTS-1:0]            almost_full;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
    logic [NUM_PORTS-1:0]            pop;
    logic [NUM_PORTS-1:0]            push;
    logic [DATA_WIDTH-1:0]           data_out;
    logic                            idle;
    logic                            stall;

    modport master (
        input  empty, almost_full, data_in,
        output pop, push, data_out, idle, stall
    );

    modport slave (
        output empty, almost_full, data_in,
        input  pop, push, data_out, idle, stall
    );
endinterface
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_rr
// Description : Round-robin arbiter moving one word per cycle from an input
//               FIFO to the output FIFO named in the word's destination field.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rr #(
    parameter int NUM_PORTS  = 4,
    parameter int DEST_WIDTH = 2,
    parameter int DATA_WIDTH = 10
) (
    input wire            clk,
    input wire            reset_L,
    arbitro_rr_if.master  bus
);
    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEST_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0]  push_q, push_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  idle_q, idle_d;
    logic                  stall_q, stall_d;

    logic [DATA_WIDTH-1:0] word [NUM_PORTS];
    logic [DEST_WIDTH-1:0] dest [NUM_PORTS];
    logic [NUM_PORTS-1:0]  eligible;

    logic [DEST_WIDTH-1:0] cand;
    logic [DEST_WIDTH-1:0] grant_idx;
    logic                  grant_found;
    logic                  pop_en;
    logic                  grant_v;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign word[i]     = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            assign dest[i]     = word[i][DATA_WIDTH-1 -: DEST_WIDTH];
            assign eligible[i] = !bus.empty[i] && !bus.almost_full[dest[i]];
        end
    endgenerate

    // Circular scan starting at rr_ptr; the pointer width wraps naturally.
    always_comb begin
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = rr_ptr_q + DEST_WIDTH'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop_en  = reset_L && ((state_q == IDLE) || (state_q == ACTIVE));
    assign grant_v = pop_en && grant_found;

    always_comb begin
        bus.pop = '0;
        if (grant_v) begin
            bus.pop[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    if (|eligible) state_d = ACTIVE;
            ACTIVE:  if (~|eligible) state_d = IDLE;
            default: state_d = INIT;
        endcase

        rr_ptr_d   = rr_ptr_q;
        push_d     = '0;
        data_out_d = data_out_q;
        if (grant_v) begin
            rr_ptr_d               = grant_idx + DEST_WIDTH'(1);
            push_d[dest[grant_idx]] = 1'b1;
            data_out_d             = word[grant_idx];
        end

        idle_d  = (state_d == IDLE);
        stall_d = (|(~bus.empty)) && (~|eligible);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= INIT;
            rr_ptr_q   <= '0;
            push_q     <= '0;
            data_out_q <= '0;
            idle_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
            idle_q     <= idle_d;
            stall_q    <= stall_d;
        end
    end

    assign bus.push     = push_q;
    assign bus.data_out = data_out_q;
    assign bus.idle     = idle_q;
    assign bus.stall    = stall_q;
endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_rr
// Description : Directed self-checking bench for arbitro_rr with a push/data
//               scoreboard fed from the expected grant of each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr;
    logic       clk = 1'b0;
    logic       reset_L;
    logic [9:0] head [4];
    logic [9:0] exp_data;
    logic [13:0] sb_q [$];
    int         errors = 0;
    int         checks = 0;

    arbitro_rr_if #(.NUM_PORTS(4), .DATA_WIDTH(10)) bus ();

    arbitro_rr #(
        .NUM_PORTS (4),
        .DEST_WIDTH(2),
        .DATA_WIDTH(10)
    ) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.data_in[i*10 +: 10] = head[i];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Checks pop now, queues the expected push/data, then checks them after the edge.
    task automatic step(input string tag, input logic [3:0] exp_pop);
        logic [3:0]  e_push;
        logic [13:0] ent;
        #1;
        chk({tag, ".pop"}, {12'h0, bus.pop}, {12'h0, exp_pop});
        e_push = '0;
        if (!reset_L) begin
            exp_data = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (exp_pop[k]) begin
                    e_push[head[k][9:8]] = 1'b1;
                    exp_data             = head[k];
                end
            end
        end
        sb_q.push_back({e_push, exp_data});
        @(posedge clk);
        #1;
        ent = sb_q.pop_front();
        chk({tag, ".push"}, {12'h0, bus.push}, {12'h0, ent[13:10]});
        chk({tag, ".data"}, {6'h0, bus.data_out}, {6'h0, ent[9:0]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_data        = '0;
        reset_L         = 1'b0;
        bus.empty       = 4'b0000;
        bus.almost_full = 4'b0000;
        for (int i = 0; i < 4; i++) head[i] = 10'h010 + 10'(i);

        // Reset held for three edges with every input non-empty
        @(posedge clk);
        #1;
        chk("rst.pop",   {12'h0, bus.pop},      16'h0);
        chk("rst.push",  {12'h0, bus.push},     16'h0);
        chk("rst.data",  {6'h0, bus.data_out},  16'h0);
        chk("rst.idle",  {15'h0, bus.idle},     16'h0);
        chk("rst.stall", {15'h0, bus.stall},    16'h0);
        step("rst1", 4'b0000);
        step("rst2", 4'b0000);
        chk("rst2.idle",  {15'h0, bus.idle},  16'h0);
        chk("rst2.stall", {15'h0, bus.stall}, 16'h0);

        reset_L = 1'b1;
        step("init", 4'b0000);

        // Fairness: rotation over all four ports, all heads to destination 0
        step("rr0", 4'b0001);
        step("rr1", 4'b0010);
        step("rr2", 4'b0100);
        step("rr3", 4'b1000);
        step("rr4", 4'b0001);

        // Per-destination backpressure, rr_ptr = 1
        head[1]         = 10'b10_00000011;
        head[2]         = 10'h055;
        bus.almost_full = 4'b0100;
        step("bp", 4'b0100);
        chk("bp.stall", {15'h0, bus.stall}, 16'h0);

        // Total block: every head to destination 3, which is almost full
        for (int i = 0; i < 4; i++) head[i] = 10'h3C0 + 10'(i);
        bus.almost_full = 4'b1000;
        step("blk", 4'b0000);
        chk("blk.stall", {15'h0, bus.stall}, 16'h1);
        chk("blk.idle",  {15'h0, bus.idle},  16'h1);

        // Idle then a single word on port 3
        bus.almost_full = 4'b0000;
        bus.empty       = 4'b1111;
        step("e1", 4'b0000);
        step("e2", 4'b0000);
        chk("e2.idle",  {15'h0, bus.idle},  16'h1);
        chk("e2.stall", {15'h0, bus.stall}, 16'h0);
        bus.empty = 4'b0111;
        head[3]   = 10'h2AB;
        step("one", 4'b1000);
        chk("one.idle", {15'h0, bus.idle}, 16'h0);

        // Mid-operation reset
        bus.empty = 4'b0000;
        for (int i = 0; i < 4; i++) head[i] = {2'(i), 8'hA0 + 8'(i)};
        step("s0", 4'b0001);
        step("s1", 4'b0010);
        reset_L = 1'b0;
        step("mrst", 4'b0000);
        chk("mrst.idle",  {15'h0, bus.idle},  16'h0);
        chk("mrst.stall", {15'h0, bus.stall}, 16'h0);
        reset_L   = 1'b1;
        bus.empty = 4'b0001;
        step("init2", 4'b0000);
        step("after", 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
